// File: rtl/seg_scan_mux.sv
// Purpose: time-multiplex four 7-segment patterns onto one shared segment bus with per-digit anodes.
// Latency: outputs are registered, one cycle behind the slot counter state they are decoded from.
// Backpressure: none; inputs are sampled once per frame into shadow registers and otherwise ignored.
module seg_scan_mux #(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] in0,
  input  logic [6:0] in1,
  input  logic [6:0] in2,
  input  logic [6:0] in3,
  input  logic [3:0] digit_en,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [1:0] cur_digit,
  output logic       frame_tick
);

  // Counter width covers 0..PRESCALE-1; PRESCALE >= 2 keeps this at least 1 bit.
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
  localparam logic [6:0]    SEG_DARK  = 7'h7F;
  localparam logic [3:0]    AN_OFF    = 4'b1111;

  // Slot timing state.
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    idx;
  logic [1:0]    idx_nxt;

  // Per-frame snapshot of the input patterns and enables.
  logic [3:0][6:0] sh;
  logic [3:0][6:0] sh_nxt;
  logic [3:0]      she;
  logic [3:0]      she_nxt;

  // Next values of the registered outputs.
  logic [6:0] seg_nxt;
  logic [3:0] an_nxt;
  logic [1:0] cur_digit_nxt;
  logic       frame_tick_nxt;

  // Decode helpers.
  logic slot_end;
  logic load;
  logic lit;

  // Slot counter and digit index advance; index wraps 3 -> 0 naturally in 2 bits.
  always_comb begin
    slot_end = (cnt == CNT_LAST);
    cnt_nxt  = slot_end ? '0 : cnt + CW'(1);
    idx_nxt  = slot_end ? idx + 2'd1 : idx;
  end

  // Snapshot the inputs only at the very start of a frame so a frame is one coherent image.
  always_comb begin
    load    = (cnt == '0) && (idx == 2'd0);
    sh_nxt  = sh;
    she_nxt = she;
    if (load) begin
      sh_nxt  = {in3, in2, in1, in0};
      she_nxt = digit_en;
    end
  end

  // Output decode uses the post-load shadow; the load cycle is always blanked,
  // so a lit digit never sees its pattern change underneath it.
  always_comb begin
    lit            = (cnt >= CNT_BLANK) && she_nxt[idx];
    seg_nxt        = SEG_DARK;
    an_nxt         = AN_OFF;
    cur_digit_nxt  = idx;
    frame_tick_nxt = slot_end && (idx == 2'd3);
    if (lit) begin
      seg_nxt = sh_nxt[idx];
      an_nxt  = ~(4'b0001 << idx);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      sh         <= {4{SEG_DARK}};
      she        <= 4'b0000;
      seg        <= SEG_DARK;
      an         <= AN_OFF;
      cur_digit  <= 2'd0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      sh         <= sh_nxt;
      she        <= she_nxt;
      seg        <= seg_nxt;
      an         <= an_nxt;
      cur_digit  <= cur_digit_nxt;
      frame_tick <= frame_tick_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Purpose: directed bench for seg_scan_mux with PRESCALE=8, BLANK=2 (32-cycle frames).
// Latency: samples 1 time unit after each rising edge; cycle 0 is the first cycle after reset release.
// Backpressure: not applicable; stimulus is a linear sequence of directed steps.
module tb_seg_scan_mux;

    localparam int PRESCALE = 8;
    localparam int BLANK    = 2;

    logic       clk;
    logic       reset;
    logic [6:0] in0, in1, in2, in3;
    logic [3:0] digit_en;
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] cur_digit;
    logic       frame_tick;

    int checks;
    int passed;
    int cyc;
    int ticks;
    int bad_an;

    seg_scan_mux #(.PRESCALE(PRESCALE), .BLANK(BLANK)) dut (
        .clk       (clk),
        .reset     (reset),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .digit_en  (digit_en),
        .seg       (seg),
        .an        (an),
        .cur_digit (cur_digit),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    initial begin
        #20000;
        $error("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $finish;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (frame_tick === 1'b1) ticks++;
    endtask

    task automatic go(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc   = 0;
        ticks = 0;
    endtask

    initial begin
        checks   = 0;
        passed   = 0;
        cyc      = 0;
        ticks    = 0;
        bad_an   = 0;
        reset    = 1'b0;
        in0      = 7'h40;
        in1      = 7'h79;
        in2      = 7'h24;
        in3      = 7'h30;
        digit_en = 4'hF;

        @(posedge clk);
        #1;
        chk("rst_seg", seg, 7'h7F);
        chk("rst_an", an, 4'b1111);
        chk("rst_cur", cur_digit, 2'd0);
        chk("rst_tick", frame_tick, 1'b0);

        do_reset();
        go(1);
        chk("c1_an_dark", an, 4'b1111);
        go(2);
        chk("c2_seg_dark", seg, 7'h7F);
        go(3);
        chk("c3_an_d0", an, 4'b1110);
        chk("c3_seg_d0", seg, 7'h40);
        chk("c3_cur", cur_digit, 2'd0);
        go(8);
        chk("c8_an_d0", an, 4'b1110);
        chk("c8_seg_d0", seg, 7'h40);
        go(9);
        chk("c9_an_blank", an, 4'b1111);
        chk("c9_seg_blank", seg, 7'h7F);
        chk("c9_cur", cur_digit, 2'd1);
        go(10);
        chk("c10_an_blank", an, 4'b1111);
        go(11);
        chk("c11_an_d1", an, 4'b1101);
        chk("c11_seg_d1", seg, 7'h79);
        go(12);
        in1 = 7'h12;
        go(16);
        chk("c16_an_d1", an, 4'b1101);
        chk("c16_seg_old", seg, 7'h79);
        go(27);
        chk("c27_an_d3", an, 4'b0111);
        chk("c27_seg_d3", seg, 7'h30);
        go(31);
        chk("c31_tick", frame_tick, 1'b0);
        go(32);
        chk("c32_an_d3", an, 4'b0111);
        chk("c32_seg_d3", seg, 7'h30);
        chk("c32_tick", frame_tick, 1'b1);
        go(33);
        chk("c33_an_wrap", an, 4'b1111);
        chk("c33_seg_wrap", seg, 7'h7F);
        chk("c33_cur_wrap", cur_digit, 2'd0);
        chk("c33_tick", frame_tick, 1'b0);
        go(43);
        chk("c43_an_d1", an, 4'b1101);
        chk("c43_seg_new", seg, 7'h12);
        go(48);
        chk("c48_seg_new", seg, 7'h12);
        go(64);
        chk("c64_tick", frame_tick, 1'b1);
        go(96);
        chk("c96_tick", frame_tick, 1'b1);
        go(100);
        chk("tick_count_0_100", ticks, 3);

        do_reset();
        go(13);
        chk("r13_an_d1", an, 4'b1101);
        chk("r13_seg_d1", seg, 7'h12);
        in0   = 7'h19;
        reset = 1'b0;
        step();
        chk("r14_an", an, 4'b1111);
        chk("r14_seg", seg, 7'h7F);
        chk("r14_cur", cur_digit, 2'd0);
        chk("r14_tick", frame_tick, 1'b0);
        reset = 1'b1;
        cyc   = 0;
        ticks = 0;
        go(3);
        chk("rr3_an_d0", an, 4'b1110);
        chk("rr3_seg_reload", seg, 7'h19);
        go(9);
        chk("rr9_an_blank", an, 4'b1111);
        chk("rr9_cur", cur_digit, 2'd1);
        go(11);
        chk("rr11_seg_d1", seg, 7'h12);

        digit_en = 4'b0101;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step();
            if (an === 4'b1101 || an === 4'b0111) bad_an++;
            if (cyc == 3) chk("en_c3_an_d0", an, 4'b1110);
            if (cyc == 19) begin
                chk("en_c19_an_d2", an, 4'b1011);
                chk("en_c19_seg_d2", seg, 7'h24);
            end
            if (cyc == 27) begin
                chk("en_c27_an_off", an, 4'b1111);
                chk("en_c27_seg_dark", seg, 7'h7F);
                chk("en_c27_cur", cur_digit, 2'd3);
            end
        end
        chk("en_no_disabled_anode", bad_an, 0);
        chk("en_c32_tick", frame_tick, 1'b1);
        go(64);
        chk("en_c64_tick", frame_tick, 1'b1);
        chk("en_tick_count", ticks, 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
